// File: rtl/ad_jesd_rx_pkg.sv
// ad_jesd_rx_pkg: shared state encoding, SOF patterns and samples-per-beat helper for the JESD RX deframer.
package ad_jesd_rx_pkg;
  typedef enum logic {WAIT_SOF, LOCKED} state_t;
  localparam logic [3:0] SOF_OFF0 = 4'b0001;
  localparam logic [3:0] SOF_OFF2 = 4'b0100;
  function automatic int calc_p(input int nl, input int nc);
    return 2 * nl / nc;
  endfunction
endpackage

// File: rtl/ad_jesd_rx_lane_align.sv
// ad_jesd_rx_lane_align: keeps the upper half of the last valid lane word and realigns by a half-beat offset.
module ad_jesd_rx_lane_align (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic        i_off2,
  input  logic [31:0] i_data,
  output logic [31:0] o_word
);
  logic [15:0] r_prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= '0;
    else if (i_valid) r_prev <= i_data[31:16];
  end
  assign o_word = i_off2 ? {i_data[15:0], r_prev} : i_data;
endmodule

// File: rtl/ad_jesd_rx_deframer.sv
// ad_jesd_rx_deframer: JESD204 RX deframer with SOF lock tracking, per-lane realignment and per-channel sample mapping.
module ad_jesd_rx_deframer
  import ad_jesd_rx_pkg::*;
#(
  parameter int NUM_LANES    = 2,
  parameter int NUM_CHANNELS = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int ERR_THRESH   = 4
) (
  input  logic                        adc_clk,
  input  logic                        adc_rstn,
  input  logic                        rx_valid,
  input  logic [3:0]                  rx_sof,
  input  logic [32*NUM_LANES-1:0]     rx_data,
  output logic                        rx_ready,
  input  logic [NUM_CHANNELS-1:0]     adc_enable,
  input  logic                        adc_status_clr,
  output logic                        adc_valid,
  output logic [16*calc_p(NUM_LANES, NUM_CHANNELS)*NUM_CHANNELS-1:0] adc_data,
  output logic                        adc_status,
  output logic                        adc_sof_err,
  output logic [15:0]                 adc_sof_err_count
);
  localparam int P = calc_p(NUM_LANES, NUM_CHANNELS);
  localparam int DW = 16 * P * NUM_CHANNELS;
  localparam logic [3:0] TH = 4'(ERR_THRESH);
  if ((2 * NUM_LANES) % NUM_CHANNELS != 0) begin : g_bad_channels
    $error("NUM_CHANNELS must divide 2*NUM_LANES");
  end
  logic                    r_valid, r_clr, r_off2, r_status, r_err, r_adc_valid;
  logic [3:0]              r_sof, r_mis;
  logic [32*NUM_LANES-1:0] r_data;
  logic [15:0]             r_cnt;
  logic [DW-1:0]           r_adc_data;
  state_t                  r_state;
  logic                    w_mism, w_drop, w_emit, w_off2;
  logic [3:0]              w_mis_nx;
  logic [DW-1:0]           w_map;
  logic [31:0]             w_al [NUM_LANES];
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      r_valid <= 1'b0;
      r_clr   <= 1'b0;
      r_sof   <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= rx_valid;
      r_clr   <= adc_status_clr;
      r_sof   <= rx_sof;
      r_data  <= rx_data;
    end
  end
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ad_jesd_rx_lane_align u_align (
      .clk    (adc_clk),
      .rst_n  (adc_rstn),
      .i_valid(r_valid),
      .i_off2 (w_off2),
      .i_data (r_data[32*l +: 32]),
      .o_word (w_al[l])
    );
  end
  assign w_off2   = (r_state == LOCKED) && r_off2;
  assign w_mism   = r_valid && (r_state == LOCKED) && (r_sof != (r_off2 ? SOF_OFF2 : SOF_OFF0));
  assign w_mis_nx = r_mis + 4'd1;
  assign w_drop   = w_mism && (w_mis_nx == TH);
  // The offset-2 locking beat only primes prev, so only an offset-0 lock emits directly.
  assign w_emit   = r_valid && ((r_state == LOCKED) ? !w_drop : (r_sof == SOF_OFF0));
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      r_state  <= WAIT_SOF;
      r_off2   <= 1'b0;
      r_mis    <= '0;
      r_status <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (r_valid && (r_state == WAIT_SOF) && (r_sof == SOF_OFF0 || r_sof == SOF_OFF2)) begin
        r_state  <= LOCKED;
        r_status <= 1'b1;
        r_off2   <= (r_sof == SOF_OFF2);
        r_mis    <= '0;
      end else if (r_valid && (r_state == LOCKED)) begin
        r_mis <= w_mism ? w_mis_nx : 4'd0;
        if (w_drop) begin
          r_state  <= WAIT_SOF;
          r_status <= 1'b0;
        end
      end
      if (r_clr) begin
        r_err <= w_mism;
        r_cnt <= {15'd0, w_mism};
      end else if (w_mism) begin
        r_err <= 1'b1;
        r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
      end
    end
  end
  // Flat sample s = 2*lane + j lands in channel s mod NUM_CHANNELS, slot s div NUM_CHANNELS.
  for (genvar g = 0; g < 2 * NUM_LANES; g++) begin : g_map
    localparam int L = g / 2;
    localparam int C = g % NUM_CHANNELS;
    localparam int K = g / NUM_CHANNELS;
    logic [15:0] w_f;
    assign w_f = (g % 2 == 1) ? {w_al[L][23:16], w_al[L][31:24]} : {w_al[L][7:0], w_al[L][15:8]};
    assign w_map[16*(P*C+K) +: 16] = adc_enable[C] ? 16'($signed(w_f) >>> (16 - SAMPLE_WIDTH)) : 16'h0;
  end
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      r_adc_valid <= 1'b0;
      r_adc_data  <= '0;
    end else begin
      r_adc_valid <= w_emit;
      if (w_emit) r_adc_data <= w_map;
    end
  end
  assign rx_ready          = 1'b1;
  assign adc_valid         = r_adc_valid;
  assign adc_data          = r_adc_data;
  assign adc_status        = r_status;
  assign adc_sof_err       = r_err;
  assign adc_sof_err_count = r_cnt;
endmodule

// File: tb/tb_ad_jesd_rx_deframer.sv
// tb_ad_jesd_rx_deframer: directed stimulus against a beat-level behavioural model, checked every cycle.
module tb_ad_jesd_rx_deframer;
  localparam int NC = 2, P = 2, TH = 4;
  localparam logic [31:0] A0 = 32'h44332211, A1 = 32'h88776655;
  logic        clk = 1'b0;
  logic        adc_rstn, rx_valid, rx_ready, adc_status_clr;
  logic        adc_valid, adc_status, adc_sof_err, v12, st12, err12, rdy12;
  logic [3:0]  rx_sof;
  logic [63:0] rx_data, adc_data, d12;
  logic [1:0]  adc_enable;
  logic [15:0] adc_sof_err_count, cnt12;
  int total = 0, bad = 0, n_out = 0, n0;
  typedef struct { bit rst; bit v; logic [63:0] d16; logic [63:0] d12; bit st; bit err; logic [15:0] cnt; } res_t;
  res_t q[$];
  res_t e;
  logic [63:0] h16 = '0, h12 = '0;
  bit m_lock = 0, m_err = 0;
  int m_off = 0, m_mis = 0, m_cnt = 0;
  logic [15:0] m_prev [2];

  always #5 clk = ~clk;

  ad_jesd_rx_deframer #(.NUM_LANES(2), .NUM_CHANNELS(2), .SAMPLE_WIDTH(16), .ERR_THRESH(TH)) u_dut (
    .adc_clk(clk), .adc_rstn(adc_rstn), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_data(rx_data),
    .rx_ready(rx_ready), .adc_enable(adc_enable), .adc_status_clr(adc_status_clr), .adc_valid(adc_valid),
    .adc_data(adc_data), .adc_status(adc_status), .adc_sof_err(adc_sof_err), .adc_sof_err_count(adc_sof_err_count));
  ad_jesd_rx_deframer #(.NUM_LANES(2), .NUM_CHANNELS(2), .SAMPLE_WIDTH(12), .ERR_THRESH(TH)) u_dut12 (
    .adc_clk(clk), .adc_rstn(adc_rstn), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_data(rx_data),
    .rx_ready(rdy12), .adc_enable(adc_enable), .adc_status_clr(adc_status_clr), .adc_valid(v12),
    .adc_data(d12), .adc_status(st12), .adc_sof_err(err12), .adc_sof_err_count(cnt12));

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ext(input logic [15:0] f, input int sw);
    int t;
    t = int'(f) >> (16 - sw);
    if (t >= (1 << (sw - 1))) t -= (1 << sw);
    return 16'(t);
  endfunction

  function automatic logic [63:0] mask(input logic [63:0] d);
    for (int c = 0; c < NC; c++) if (!adc_enable[c]) d[32*c +: 32] = '0;
    return d;
  endfunction

  task automatic step(input bit v, input logic [3:0] sof, input logic [31:0] w0, input logic [31:0] w1, input bit clr = 0);
    res_t r;
    logic [31:0] w [2];
    logic [31:0] a;
    logic [15:0] f;
    bit mism;
    int s;
    @(negedge clk);
    rx_valid = v; rx_sof = sof; rx_data = {w1, w0}; adc_status_clr = clr;
    w[0] = w0; w[1] = w1; mism = 0;
    r = '{default: '0};
    if (v) begin
      if (!m_lock) begin
        if (sof == 4'b0001) begin m_lock = 1; m_off = 0; m_mis = 0; r.v = 1; end
        else if (sof == 4'b0100) begin m_lock = 1; m_off = 2; m_mis = 0; end
      end else if (sof == ((m_off == 2) ? 4'b0100 : 4'b0001)) begin
        m_mis = 0; r.v = 1;
      end else begin
        mism = 1; m_mis++;
        if (m_mis == TH) m_lock = 0; else r.v = 1;
      end
      for (int l = 0; l < 2; l++) begin
        a = (m_off == 2) ? {w[l][15:0], m_prev[l]} : w[l];
        for (int j = 0; j < 2; j++) begin
          f = j ? {a[23:16], a[31:24]} : {a[7:0], a[15:8]};
          s = 2 * l + j;
          r.d16[16*((s % NC) * P + s / NC) +: 16] = ext(f, 16);
          r.d12[16*((s % NC) * P + s / NC) +: 16] = ext(f, 12);
        end
        m_prev[l] = w[l][31:16];
      end
    end
    if (clr) begin m_err = mism; m_cnt = int'(mism); end
    else if (mism) begin m_err = 1; m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1; end
    r.st = m_lock; r.err = m_err; r.cnt = 16'(m_cnt);
    q.push_back(r);
  endtask

  task automatic do_reset();
    res_t z;
    z = '{default: '0};
    z.rst = 1;
    @(negedge clk);
    adc_rstn = 0; rx_valid = 0; adc_status_clr = 0;
    foreach (q[i]) q[i] = z;
    q.push_back(z);
    m_lock = 0; m_off = 0; m_mis = 0; m_err = 0; m_cnt = 0; m_prev[0] = '0; m_prev[1] = '0;
    repeat (2) begin @(negedge clk); q.push_back(z); end
    @(negedge clk);
    adc_rstn = 1;
    q.push_back(z);
  endtask

  always @(posedge clk) begin
    #1;
    if (adc_valid) n_out++;
    if (q.size() >= 2) begin
      e = q.pop_front();
      if (e.rst) begin h16 = '0; h12 = '0; end
      else if (e.v) begin h16 = mask(e.d16); h12 = mask(e.d12); end
      chk("valid", adc_valid, 64'(e.v));
      chk("valid12", v12, 64'(e.v));
      chk("data", adc_data, h16);
      chk("data12", d12, h12);
      chk("status", adc_status, 64'(e.st));
      chk("sof_err", adc_sof_err, 64'(e.err));
      chk("err_count", adc_sof_err_count, 64'(e.cnt));
      chk("ready", rx_ready, 64'd1);
    end
  end

  initial begin
    adc_rstn = 0; rx_valid = 0; rx_sof = 0; rx_data = 0; adc_enable = 2'b11; adc_status_clr = 0;
    m_prev[0] = '0; m_prev[1] = '0;
    do_reset();
    chk("rst_valid", adc_valid, 0); chk("rst_data", adc_data, 0); chk("rst_status", adc_status, 0);
    step(1, 4'b0001, A0, A1); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("off0_valid", adc_valid, 1); chk("off0_data", adc_data, 64'h7788_3344_5566_1122);
    chk("off0_status", adc_status, 1);
    do_reset();
    step(1, 4'b0100, A0, A1); step(1, 4'b0100, 32'hCCBB_AA99, 32'h00FF_EEDD); step(0, 0, 0, 0);
    chk("off2_first_valid", adc_valid, 0); chk("off2_status", adc_status, 1);
    step(0, 0, 0, 0);
    chk("off2_valid", adc_valid, 1); chk("off2_data", adc_data, 64'hDDEE_99AA_7788_3344);
    n0 = n_out;
    repeat (3) step(1, 4'b0001, $urandom, $urandom);
    step(1, 4'b0100, $urandom, $urandom); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("err3_beats", 64'(n_out - n0), 4); chk("err3_count", adc_sof_err_count, 3);
    chk("err3_lock", adc_status, 1); chk("err3_flag", adc_sof_err, 1);
    n0 = n_out;
    repeat (4) step(1, 4'b1000, $urandom, $urandom);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("drop_beats", 64'(n_out - n0), 3); chk("drop_status", adc_status, 0);
    chk("drop_count", adc_sof_err_count, 7);
    n0 = n_out;
    step(1, 4'b0001, $urandom, $urandom); step(0, 0, 0, 0); step(1, 4'b0001, $urandom, $urandom);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("gap_beats", 64'(n_out - n0), 2);
    step(1, 4'b0001, 32'h0000_0580, A1); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("sext12", d12[15:0], 16'hF800); chk("sext16", adc_data[15:0], 16'h8005);
    adc_enable = 2'b01;
    step(1, 4'b0001, A0, A1); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("en_ch1_zero", adc_data[63:32], 0); chk("en_ch0", adc_data[31:0], 32'h5566_1122);
    adc_enable = 2'b11;
    step(1, 4'b0100, A0, A1, 1); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("clr_mism_count", adc_sof_err_count, 1); chk("clr_mism_flag", adc_sof_err, 1);
    chk("clr_mism_lock", adc_status, 1);
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("clr_count", adc_sof_err_count, 0); chk("clr_flag", adc_sof_err, 0);
    do_reset();
    step(1, 4'b0100, A0, A1); step(1, 4'b0100, $urandom, $urandom); step(1, 4'b0100, $urandom, $urandom);
    step(1, 4'b0001, $urandom, $urandom);
    do_reset();
    chk("mid_rst_valid", adc_valid, 0); chk("mid_rst_data", adc_data, 0);
    chk("mid_rst_status", adc_status, 0); chk("mid_rst_count", adc_sof_err_count, 0);
    n0 = n_out;
    step(1, 4'b0000, $urandom, $urandom); step(1, 4'b0010, $urandom, $urandom);
    step(1, 4'b0011, $urandom, $urandom); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("nolock_beats", 64'(n_out - n0), 0); chk("nolock_status", adc_status, 0);
    step(1, 4'b0001, A0, A1); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("relock_valid", adc_valid, 1); chk("relock_data", adc_data, 64'h7788_3344_5566_1122);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
